// File: rtl/nx_fifo_ctrl_wm.sv
// rtl/nx_fifo_ctrl_wm.sv - parametrised FIFO pointer/occupancy controller with watermarks
//
// Purpose: generates read/write addresses for an external RAM of any DEPTH >= 2,
// tracks occupancy, and reports registered status flags, a high-water mark and
// sticky overflow/underflow errors.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clear                synchronous flush (hwm and sticky flags retained)
//   wen, ren             write / read requests
//   err_clr, hwm_clr     clear sticky errors / clear high-water mark
//   wptr, rptr           RAM write / read addresses
//   used_slots           current occupancy
//   free_slots           DEPTH - used_slots
//   empty, full          occupancy == 0 / == DEPTH
//   almost_empty         used_slots <= AEMPTY_THRESH
//   almost_full          used_slots >= AFULL_THRESH
//   overflow, underflow  combinational pulses: rejected write / rejected read
//   ovf_sticky, unf_sticky  latched error flags
//   hwm                  highest occupancy since rst/hwm_clr
module nx_fifo_ctrl_wm #(
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wen,
  input  logic          ren,
  input  logic          err_clr,
  input  logic          hwm_clr,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [CW-1:0] used_slots,
  output logic [CW-1:0] free_slots,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow,
  output logic          ovf_sticky,
  output logic          unf_sticky,
  output logic [CW-1:0] hwm
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Explicit wrap so non-power-of-two depths address only 0..DEPTH-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] used_next;
  logic [AW-1:0] wptr_next;
  logic [AW-1:0] rptr_next;
  logic          ovf_next;
  logic          unf_next;
  logic [CW-1:0] hwm_next;

  always_comb begin
    // Acceptance uses the registered flags, so a write at full is dropped
    // even when a read frees a slot in the same cycle.
    wr_acc    = wen & ~full;
    rd_acc    = ren & ~empty;
    overflow  = wen & full;
    underflow = ren & empty;
    used_next = used_slots;
    wptr_next = wptr;
    rptr_next = rptr;
    ovf_next  = ovf_sticky;
    unf_next  = unf_sticky;

    if (clear) begin
      // Flush: error pulses in a clear cycle do not latch.
      used_next = '0;
      wptr_next = '0;
      rptr_next = '0;
      ovf_next  = err_clr ? 1'b0 : ovf_sticky;
      unf_next  = err_clr ? 1'b0 : unf_sticky;
    end else begin
      if (wr_acc) wptr_next = ptr_inc(wptr);
      if (rd_acc) rptr_next = ptr_inc(rptr);
      case ({wr_acc, rd_acc})
        2'b10:   used_next = used_slots + 1'b1;
        2'b01:   used_next = used_slots - 1'b1;
        default: used_next = used_slots;
      endcase
      ovf_next = err_clr ? 1'b0 : (ovf_sticky | overflow);
      unf_next = err_clr ? 1'b0 : (unf_sticky | underflow);
    end

    hwm_next = hwm_clr ? used_next : ((used_next > hwm) ? used_next : hwm);
  end

  // All status is derived from used_next so flags and count change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      used_slots   <= '0;
      free_slots   <= DEPTH_C;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      ovf_sticky   <= 1'b0;
      unf_sticky   <= 1'b0;
      hwm          <= '0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      used_slots   <= used_next;
      free_slots   <= DEPTH_C - used_next;
      empty        <= (used_next == '0);
      full         <= (used_next == DEPTH_C);
      almost_empty <= (used_next <= AEMPTY_C);
      almost_full  <= (used_next >= AFULL_C);
      ovf_sticky   <= ovf_next;
      unf_sticky   <= unf_next;
      hwm          <= hwm_next;
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i <= DEPTH; i++) begin : g_cov_used
    cover property (@(posedge clk) used_slots == CW'(i));
  end
`endif

endmodule

// File: tb/tb_nx_fifo_ctrl_wm.sv
// tb/tb_nx_fifo_ctrl_wm.sv - self-checking bench for nx_fifo_ctrl_wm at DEPTH 4 and 5
module tb_nx_fifo_ctrl_wm;

  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, wen = 1'b0, ren = 1'b0, err_clr = 1'b0, hwm_clr = 1'b0;

  logic [1:0] wptr_a, rptr_a;
  logic [2:0] used_a, free_a, hwm_a;
  logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a, ovfs_a, unfs_a;
  logic [2:0] wptr_b, rptr_b;
  logic [2:0] used_b, free_b, hwm_b;
  logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b, ovfs_b, unfs_b;

  always #5 clk = ~clk;

  nx_fifo_ctrl_wm #(.DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .ren(ren), .err_clr(err_clr), .hwm_clr(hwm_clr),
    .wptr(wptr_a), .rptr(rptr_a), .used_slots(used_a), .free_slots(free_a), .empty(empty_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a), .overflow(ovf_a), .underflow(unf_a),
    .ovf_sticky(ovfs_a), .unf_sticky(unfs_a), .hwm(hwm_a));

  nx_fifo_ctrl_wm #(.DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .ren(ren), .err_clr(err_clr), .hwm_clr(hwm_clr),
    .wptr(wptr_b), .rptr(rptr_b), .used_slots(used_b), .free_slots(free_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b), .overflow(ovf_b), .underflow(unf_b),
    .ovf_sticky(ovfs_b), .unf_sticky(unfs_b), .hwm(hwm_b));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: plain counts and modulo pointers per instance.
  int dep[2] = '{4, 5};
  int m_used[2], m_wp[2], m_rp[2], m_hwm[2], m_ovf[2], m_unf[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_used[k] = 0; m_wp[k] = 0; m_rp[k] = 0; m_hwm[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
        int was_full, was_empty, wa, ra;
        was_full  = (m_used[k] == dep[k]);
        was_empty = (m_used[k] == 0);
        wa = wen && !was_full;
        ra = ren && !was_empty;
        if (clear) begin
          m_used[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
          if (err_clr) begin m_ovf[k] = 0; m_unf[k] = 0; end
        end else begin
          m_used[k] = m_used[k] + wa - ra;
          if (wa) m_wp[k] = (m_wp[k] + 1) % dep[k];
          if (ra) m_rp[k] = (m_rp[k] + 1) % dep[k];
          if (err_clr) begin
            m_ovf[k] = 0; m_unf[k] = 0;
          end else begin
            if (wen && was_full) m_ovf[k] = 1;
            if (ren && was_empty) m_unf[k] = 1;
          end
        end
        if (hwm_clr) m_hwm[k] = m_used[k];
        else if (m_used[k] > m_hwm[k]) m_hwm[k] = m_used[k];
      end
    end
  end

  task automatic cmp_inst(input int k, input int wp, input int rp, input int used, input int free,
                          input int emp, input int ful, input int ae, input int af, input int ov,
                          input int un, input int os, input int us, input int hw);
    string p;
    p = (k == 0) ? "d4" : "d5";
    chk({p, "_wptr"}, wp, m_wp[k]);
    chk({p, "_rptr"}, rp, m_rp[k]);
    chk({p, "_used"}, used, m_used[k]);
    chk({p, "_free"}, free, dep[k] - m_used[k]);
    chk({p, "_empty"}, emp, int'(m_used[k] == 0));
    chk({p, "_full"}, ful, int'(m_used[k] == dep[k]));
    chk({p, "_almost_empty"}, ae, int'(m_used[k] <= 1));
    chk({p, "_almost_full"}, af, int'(m_used[k] >= dep[k] - 1));
    chk({p, "_overflow"}, ov, int'(wen && m_used[k] == dep[k]));
    chk({p, "_underflow"}, un, int'(ren && m_used[k] == 0));
    chk({p, "_ovf_sticky"}, os, m_ovf[k]);
    chk({p, "_unf_sticky"}, us, m_unf[k]);
    chk({p, "_hwm"}, hw, m_hwm[k]);
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp_inst(0, wptr_a, rptr_a, used_a, free_a, empty_a, full_a, ae_a, af_a, ovf_a, unf_a, ovfs_a, unfs_a, hwm_a);
      cmp_inst(1, wptr_b, rptr_b, used_b, free_b, empty_b, full_b, ae_b, af_b, ovf_b, unf_b, ovfs_b, unfs_b, hwm_b);
    end
  end

  task automatic drive(input bit r, input bit w, input bit rd, input bit c, input bit ec, input bit hc);
    @(negedge clk);
    rst = r; wen = w; ren = rd; clear = c; err_clr = ec; hwm_clr = hc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input bit c, input bit ec, input bit hc);
    drive(r, w, rd, c, ec, hc);
    tick();
  endtask

  int exp_ae[5] = '{1, 0, 0, 0, 0};
  int exp_af[5] = '{0, 0, 1, 1, 1};

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_d5_used", used_b, 0);
    chk("rst_d5_free", free_b, 5);
    chk("rst_d5_empty", empty_b, 1);
    chk("rst_d5_ae", ae_b, 1);
    chk("rst_d5_af", af_b, 0);
    chk("rst_d4_free", free_a, 4);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("wr%0d_d4_ae", i), ae_a, exp_ae[i]);
      chk($sformatf("wr%0d_d4_af", i), af_a, exp_af[i]);
      chk($sformatf("wr%0d_d5_wptr", i), wptr_b, (i + 1) % 5);
      chk($sformatf("wr%0d_d5_full", i), full_b, int'(i == 4));
    end
    chk("wr_d4_ovf_sticky", ovfs_a, 1);
    chk("wr_d5_ovf_sticky", ovfs_b, 0);
    chk("wr_d5_hwm", hwm_b, 5);
    chk("wr_d4_hwm", hwm_a, 4);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 0);
      chk($sformatf("rd%0d_d5_rptr", i), rptr_b, (i + 1) % 5);
    end
    chk("rd_d5_empty", empty_b, 1);
    chk("rd_d4_unf_sticky", unfs_a, 1);
    chk("rd_d5_unf_sticky", unfs_b, 0);

    step(0, 0, 0, 0, 1, 0);
    chk("errclr_d4_ovf", ovfs_a, 0);
    chk("errclr_d4_unf", unfs_a, 0);

    repeat (4) step(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    #1;
    chk("full_wr_rd_d4_overflow", ovf_a, 1);
    chk("full_wr_rd_d5_overflow", ovf_b, 0);
    tick();
    chk("full_wr_rd_d4_used", used_a, 3);
    chk("full_wr_rd_d4_rptr", rptr_a, 1);
    chk("full_wr_rd_d4_wptr", wptr_a, 0);
    chk("full_wr_rd_d4_ovfs", ovfs_a, 1);
    chk("full_wr_rd_d5_used", used_b, 4);

    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (10) step(0, 1, 1, 0, 0, 0);
    chk("both10_d4_used", used_a, 2);
    chk("both10_d4_rptr", rptr_a, 0);
    chk("both10_d4_wptr", wptr_a, 2);
    chk("both10_d5_used", used_b, 3);

    step(0, 1, 0, 0, 0, 1);
    chk("hwmclr_wr_d4_used", used_a, 3);
    chk("hwmclr_wr_d4_hwm", hwm_a, 3);
    step(0, 1, 0, 1, 0, 0);
    chk("clear_d4_used", used_a, 0);
    chk("clear_d4_empty", empty_a, 1);
    chk("clear_d4_wptr", wptr_a, 0);
    chk("clear_d4_rptr", rptr_a, 0);
    chk("clear_d4_hwm", hwm_a, 3);
    step(0, 0, 0, 0, 0, 1);
    chk("hwmclr_d4_hwm", hwm_a, 0);

    repeat (5) step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    chk("pre_rst_d4_used", used_a, 2);
    chk("pre_rst_d4_ovfs", ovfs_a, 1);
    step(1, 1, 1, 0, 0, 0);
    chk("midrst_d4_used", used_a, 0);
    chk("midrst_d4_free", free_a, 4);
    chk("midrst_d4_empty", empty_a, 1);
    chk("midrst_d4_full", full_a, 0);
    chk("midrst_d4_ae", ae_a, 1);
    chk("midrst_d4_af", af_a, 0);
    chk("midrst_d4_wptr", wptr_a, 0);
    chk("midrst_d4_rptr", rptr_a, 0);
    chk("midrst_d4_ovfs", ovfs_a, 0);
    chk("midrst_d4_hwm", hwm_a, 0);
    step(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
